// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state encodings,
// opcode constants, ALUOp codes (also consumed by ALU_control), and the Moore
// output decode used by the main control FSM.
// Optional feature macro: IMM_EXT_EN (extended immediate ALU instructions).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALUOP_FUNCT = 4'b0000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0001;
    localparam logic [3:0] ALUOP_ADD   = 4'b0010;
    localparam logic [3:0] ALUOP_LUI   = 4'b0011;
    localparam logic [3:0] ALUOP_ADDIU = 4'b0100;
    localparam logic [3:0] ALUOP_SLTI  = 4'b0101;
    localparam logic [3:0] ALUOP_SLTIU = 4'b0110;
    localparam logic [3:0] ALUOP_ANDI  = 4'b0111;
    localparam logic [3:0] ALUOP_ORI   = 4'b1000;
    localparam logic [3:0] ALUOP_XORI  = 4'b1001;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full set of datapath control lines driven by the main FSM.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    // Moore output decode: every line not named for a state stays 0, and the
    // unused encodings 13-15 produce an all-zero control word.
    function automatic ctrl_t moore_outputs(input state_t st,
                                            input logic [3:0] i_alu_op,
                                            input logic zext);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = i_alu_op;
                c.zero_ext  = zext;
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
            end
            S_ILLEGAL: begin
                c.illegal_op = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode decoder for the multicycle main control: picks the
// state that follows DECODE, the ALUOp for I-type execution and whether the
// immediate is zero-extended.
// Optional feature macro: IMM_EXT_EN (addiu/slti/sltiu/andi/ori/xori).
module mc_opdecode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output state_t     next_state,
    output logic [3:0] alu_op,
    output logic       zext
);

    // Opcode classification; anything unrecognised lands in ILLEGAL.
    always_comb begin
        next_state = S_ILLEGAL;
        alu_op     = ALUOP_ADD;
        zext       = 1'b0;
        case (opcode)
            OP_LW, OP_SW: next_state = S_MEM_ADDR;
            OP_R:         next_state = S_R_EXEC;
            OP_BEQ:       next_state = S_BRANCH;
            OP_J:         next_state = S_JUMP;
            OP_ADDI: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_ADD;
            end
            OP_LUI: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_LUI;
            end
`ifdef IMM_EXT_EN
            OP_ADDIU: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_ADDIU;
            end
            OP_SLTI: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_SLTI;
            end
            OP_SLTIU: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_SLTIU;
            end
            OP_ANDI: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_ANDI;
                zext       = 1'b1;
            end
            OP_ORI: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_ORI;
                zext       = 1'b1;
            end
            OP_XORI: begin
                next_state = S_I_EXEC;
                alu_op     = ALUOP_XORI;
                zext       = 1'b1;
            end
`else
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
                next_state = S_ILLEGAL;
`endif
            default: next_state = S_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, drives the
// datapath enables and the 4-bit ALUOp for ALU_control, and counts retired
// instructions. Control outputs are registered alongside the state so they
// always reflect the current state with no decode glitches.
// Optional feature macro: IMM_EXT_EN (extended immediate ALU instructions).
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ZeroExt,
    output logic [1:0]       PCSource,
    output logic [3:0]       ALUOp,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       alu_op_q;
    logic [3:0]       alu_op_d;
    logic             zext_q;
    logic             zext_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] instr_cnt_q;
    logic             retire;

    state_t           dec_next;
    logic [3:0]       dec_alu_op;
    logic             dec_zext;

    mc_opdecode u_opdecode (
        .opcode     (opcode),
        .next_state (dec_next),
        .alu_op     (dec_alu_op),
        .zext       (dec_zext)
    );

    // Next-state selection plus the I-type operation that will be in effect next cycle.
    always_comb begin
        state_d  = S_FETCH;
        alu_op_d = (state_q == S_DECODE) ? dec_alu_op : alu_op_q;
        zext_d   = (state_q == S_DECODE) ? dec_zext : zext_q;
        retire   = 1'b0;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = dec_next;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_MEM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_WR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State, latched I-type op, registered control word and retire counter; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            alu_op_q    <= ALUOP_ADD;
            zext_q      <= 1'b0;
            ctrl_q      <= moore_outputs(S_FETCH, ALUOP_ADD, 1'b0);
            instr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            zext_q   <= zext_d;
            ctrl_q   <= moore_outputs(state_d, alu_op_d, zext_d);
            if (retire) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.i_or_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ZeroExt     = ctrl_q.zero_ext;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUOp       = ctrl_q.alu_op;
    assign illegal_op  = ctrl_q.illegal_op;
    assign state       = state_q;
    assign instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control. A narrow counter width is
// used so that wrap-around is reached in a short run.
// Optional feature macro: IMM_EXT_EN (expectations follow the same macro).
module tb_multicycle_main_control;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt, illegal_op;
    logic [1:0]    ALUSrcB, PCSource;
    logic [3:0]    ALUOp, state;
    logic [CW-1:0] instr_cnt;
    logic [18:0]   act_ctrl;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;

    multicycle_main_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
        .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt,
                       PCSource, ALUOp, illegal_op};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit ext_op(input logic [5:0] op);
        return (op >= 6'h09 && op <= 6'h0E);
    endfunction

    function automatic bit is_itype(input logic [5:0] op);
`ifdef IMM_EXT_EN
        return (op == 6'h08 || op == 6'h0F || ext_op(op));
`else
        return (op == 6'h08 || op == 6'h0F);
`endif
    endfunction

    // Sequence of states an opcode visits, starting at FETCH.
    task automatic path_of(input logic [5:0] op, output int len, output int st[5]);
        st = '{0, 1, 12, 0, 0};
        len = 3;
        if (op == 6'h23)      begin st = '{0, 1, 2, 3, 4};  len = 5; end
        else if (op == 6'h2B) begin st = '{0, 1, 2, 5, 0};  len = 4; end
        else if (op == 6'h00) begin st = '{0, 1, 6, 7, 0};  len = 4; end
        else if (op == 6'h04) begin st = '{0, 1, 8, 0, 0};  len = 3; end
        else if (op == 6'h02) begin st = '{0, 1, 9, 0, 0};  len = 3; end
        else if (is_itype(op)) begin st = '{0, 1, 10, 11, 0}; len = 4; end
    endtask

    // Expected control word for a state while executing opcode op.
    function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] op);
        logic pcw = 0, pcc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
        logic rd = 0, rw = 0, sa = 0, zx = 0, ill = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [3:0] ao = 0;
        case (st)
            0:  begin pcw = 1; mr = 1; irw = 1; sb = 2'b01; ao = 4'd2; end
            1:  begin sb = 2'b11; ao = 4'd2; end
            2:  begin sa = 1; sb = 2'b10; ao = 4'd2; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin sa = 1; sb = 2'b00; ao = 4'd0; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 4'd1; pcc = 1; ps = 2'b01; end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin
                sa = 1; sb = 2'b10;
                if (op == 6'h08) ao = 4'd2;
                else if (op == 6'h0F) ao = 4'd3;
                else ao = 4'(op - 6'd5);
`ifdef IMM_EXT_EN
                zx = (op >= 6'h0C && op <= 6'h0E);
`endif
            end
            11: rw = 1;
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, zx, ps, ao, ill};
    endfunction

    // Run one instruction from FETCH (at a falling edge) and check every cycle.
    task automatic run_instr(input logic [5:0] op);
        int len;
        int st[5];
        path_of(op, len, st);
        opcode = op;
        for (int i = 0; i < len; i++) begin
            check($sformatf("state op%0h c%0d", op, i), 32'(state), 32'(st[i]));
            check($sformatf("ctrl op%0h c%0d", op, i), 32'(act_ctrl), 32'(exp_ctrl(st[i], op)));
            check($sformatf("cnt op%0h c%0d", op, i), 32'(instr_cnt), 32'(model_cnt));
            @(posedge clk);
            @(negedge clk);
        end
        if (st[len-1] != 12) model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    typedef struct {
        logic [5:0] op;
        int         cycles;
        int         retires;
    } vec_t;

    vec_t vecs[10];
    logic [5:0] legal[13] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B,
                              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    initial begin
        rst = 1'b1;
        opcode = 6'h00;
        repeat (2) @(negedge clk);
        check("reset state", 32'(state), 32'd0);
        check("reset ctrl", 32'(act_ctrl), 32'(exp_ctrl(0, 6'h00)));
        check("reset cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b0;
        model_cnt = 0;

        // Directed cycle-by-cycle sequences
        run_instr(6'h23);
        check("lw retired", 32'(instr_cnt), 32'd1);
        run_instr(6'h00);
        run_instr(6'h04);
        run_instr(6'h0D);
        run_instr(6'h3F);
        run_instr(6'h0C);

        // Table: latency and retire count per opcode
        vecs[0] = '{6'h23, 5, 1};
        vecs[1] = '{6'h2B, 4, 1};
        vecs[2] = '{6'h00, 4, 1};
        vecs[3] = '{6'h04, 3, 1};
        vecs[4] = '{6'h02, 3, 1};
        vecs[5] = '{6'h08, 4, 1};
        vecs[6] = '{6'h0F, 4, 1};
`ifdef IMM_EXT_EN
        vecs[7] = '{6'h0D, 4, 1};
`else
        vecs[7] = '{6'h0D, 3, 0};
`endif
        vecs[8] = '{6'h3F, 3, 0};
        vecs[9] = '{6'h01, 3, 0};
        for (int v = 0; v < 10; v++) begin
            int cyc;
            int cnt0;
            cnt0 = int'(instr_cnt);
            opcode = vecs[v].op;
            cyc = 0;
            do begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end while (state != 4'd0 && cyc < 10);
            check($sformatf("latency op%0h", vecs[v].op), 32'(cyc), 32'(vecs[v].cycles));
            check($sformatf("retire op%0h", vecs[v].op), 32'(instr_cnt),
                  32'((cnt0 + vecs[v].retires) % (1 << CW)));
            model_cnt = (model_cnt + vecs[v].retires) % (1 << CW);
        end

        // Randomized instruction stream against the model
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 3) != 0) op = legal[$urandom_range(0, 12)];
            else op = 6'($urandom_range(0, 63));
            run_instr(op);
        end

        // Counter wrap: bring the count to all-ones, then retire one jump
        for (int k = 0; k < 70 && model_cnt != (1 << CW) - 1; k++) run_instr(6'h02);
        check("cnt all ones", 32'(instr_cnt), 32'((1 << CW) - 1));
        run_instr(6'h02);
        check("cnt wrap", 32'(instr_cnt), 32'd0);
        run_instr(6'h3F);
        check("illegal no retire", 32'(instr_cnt), 32'd0);

        // Reset in the middle of sw MEM_WR
        opcode = 6'h2B;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("sw in MEM_WR", 32'(state), 32'd5);
        check("sw MemWrite", 32'(MemWrite), 32'd1);
        rst = 1'b1;
        #1;
        check("rst MemWrite", 32'(MemWrite), 32'd0);
        check("rst state", 32'(state), 32'd0);
        check("rst cnt", 32'(instr_cnt), 32'd0);
        check("rst ctrl", 32'(act_ctrl), 32'(exp_ctrl(0, 6'h00)));
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        run_instr(6'h2B);
        check("sw after reset", 32'(instr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
